nearest_sphere_hit: RTL and testbench
=====================================

Name: nearest_sphere_hit

Overview:
Sequential, parametrised ray–sphere intersection engine. For one ray it scans a table of up to N_SPHERES spheres, each with its own radius, and returns the nearest positive hit distance and the index of the sphere that produced it. It shares one multiplier and one iterative square-root unit across all spheres. It sits between the ray generator (start/ray handshake) and the shader (result handshake), and it reads sphere data from a synchronous sphere RAM.

Parameters:
W, 32, fixed-point word width (signed two's complement)
FRAC, 16, fractional bits; W+FRAC must be even
N_SPHERES, 16, sphere table depth
IDX_W, $clog2(N_SPHERES), index width

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
start  in  1  request to begin a scan
start_ready  out  1  high in IDLE only
ray_dir  in  3xW  unit direction {x,y,z}; ray origin is 0; latched on accept
tmax  in  W  initial best distance; latched on accept
num_spheres  in  IDX_W+1  spheres to scan; latched and clipped to N_SPHERES
sphere_addr  out  IDX_W  sphere RAM read address
sphere_center  in  3xW  RAM data, valid 1 cycle after sphere_addr
sphere_radius  in  W  RAM data, valid 1 cycle after sphere_addr
result_valid  out  1  result available
result_ready  in  1  consumer accepts the result
hit  out  1  at least one sphere accepted
hit_index  out  IDX_W  index of the nearest accepted sphere
t_hit  out  W  nearest distance; equals tmax if no hit
busy  out  1  state != IDLE

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; start_ready=1 after release; result_valid=0, hit=0, hit_index=0, t_hit=0, sphere_addr=0, busy=0. A reset during a scan discards it and produces no result.
- mul(a,b): signed WxW to 2W product, then take bits [W+FRAC-1:FRAC] (arithmetic truncation). No saturation; wraps mod 2^W. Add/sub are also W-bit wrapping. All compares are signed.
- States:
  - IDLE: on start=1, latch ray_dir, tmax (into tbest), n=min(num_spheres,N_SPHERES); set idx=0, hit=0. If n=0, go to DONE; otherwise go to FETCH. start is ignored in every other state.
  - FETCH (1 cycle): sphere_addr=idx.
  - LOAD (1 cycle): register center c and radius r.
  - MAC (8 cycles, one multiply per cycle, fixed order):
    - v = dx*cx + dy*cy + dz*cz
    - cc = cx^2 + cy^2 + cz^2
    - vsq = v*v
    - rsq = r*r
  - TEST (1 cycle): if tbest > v-r and rsq > cc-vsq, set disc = rsq-(cc-vsq) and go to SQRT; else go to NEXT.
  - SQRT (SQRT_CYC=(W+FRAC)/2 cycles): restoring integer square root of disc<<FRAC; one result bit per cycle; result s is floor, W bits.
  - UPDATE (1 cycle): t=v-s. If t>0 and t<tbest, then tbest=t, hit=1, hit_index=idx. The compare is strict, so on equal t the lower index wins.
  - NEXT (1 cycle): if idx=n-1 go to DONE; else idx=idx+1 and go to FETCH.
  - DONE: result_valid=1 with hit/hit_index/t_hit=tbest held stable. When result_ready=1, go to IDLE and drop result_valid next cycle.
- Per-sphere cost:
  - 12 cycles when TEST rejects.
  - 13+SQRT_CYC cycles otherwise (37 at defaults).
- Accept-to-result_valid latency is 1 cycle when n=0.
- Result outputs keep their value after leaving DONE and are overwritten only by the next scan.
- sphere_addr changes only in IDLE and NEXT.

Test Plan:
- Single hit: ray_dir=(0,0,0x10000), c=(0,0,0x640000) (100), r=0x200000 (32), tmax=0x7FFFFFFF, n=1 -> hit=1, hit_index=0, t_hit=0x440000 (68); result_valid exactly 1+37+1 cycles after accept.
- Miss: c=(0x640000,0,0x640000), r=32 -> TEST rejects (bsq=10000>1024); hit=0, t_hit=0x7FFFFFFF, 12-cycle scan.
- Nearest-of-many, tie, and behind:
  - sphere0 at z=200, sphere1 at z=100, r=32, n=2 -> hit_index=1, t_hit=0x440000.
  - two identical spheres -> hit_index=0.
  - sphere at z=-100 -> t=-132 rejected, hit=0.
- Clip and empty: n=0 -> result_valid within 2 cycles, hit=0, t_hit=tmax. num_spheres=N_SPHERES+3 -> only N_SPHERES addresses issued (0..N_SPHERES-1).
- Handshake: hold result_ready=0 for 10 cycles -> outputs stable and start ignored (start_ready=0); assert result_ready -> IDLE next cycle and a new start is accepted.
- Reset mid-SQRT: pulse Reset_n low asynchronously -> all outputs go to reset values immediately, no result_valid, and the next scan is correct.

Source files
------------

// File: rtl/nearest_sphere_hit.sv
`default_nettype none
// ============================================================================
// nearest_sphere_hit -- scans a sphere table for one ray and reports the
// nearest positive hit, sharing one multiplier and one restoring sqrt unit.
// Revision: 1.0
// ============================================================================
module nearest_sphere_hit #(
    parameter int W         = 32,
    parameter int FRAC      = 16,
    parameter int N_SPHERES = 16,
    parameter int IDX_W     = $clog2(N_SPHERES)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    output logic             start_ready,
    input  logic [3*W-1:0]   ray_dir,
    input  logic [W-1:0]     tmax,
    input  logic [IDX_W:0]   num_spheres,
    output logic [IDX_W-1:0] sphere_addr,
    input  logic [3*W-1:0]   sphere_center,
    input  logic [W-1:0]     sphere_radius,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             hit,
    output logic [IDX_W-1:0] hit_index,
    output logic [W-1:0]     t_hit,
    output logic             busy
);
    localparam int c_SQ_W     = (W + FRAC) / 2;
    localparam int c_SQRT_CYC = c_SQ_W;
    localparam int c_CNT_W    = (c_SQRT_CYC > 8) ? $clog2(c_SQRT_CYC) : 3;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_LOAD   = 4'd2,
        S_MAC    = 4'd3,
        S_TEST   = 4'd4,
        S_SQRT   = 4'd5,
        S_UPDATE = 4'd6,
        S_NEXT   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t r_state, w_state_nx;

    logic signed [W-1:0]   r_dx, r_dy, r_dz, r_cx, r_cy, r_cz, r_r;
    logic signed [W-1:0]   r_v, r_cc, r_vsq, r_rsq, r_tbest;
    logic [IDX_W:0]        r_n;
    logic [IDX_W-1:0]      r_idx, r_best_idx, r_hidx_o;
    logic                  r_hit, r_hit_o;
    logic [W-1:0]          r_t_o;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [2*c_SQ_W-1:0]   r_rad;
    logic [c_SQ_W-1:0]     r_rem, r_root;

    logic signed [W-1:0]   w_ma, w_mb, w_mp, w_vmr, w_ccmv, w_disc, w_s, w_t;
    logic signed [2*W-1:0] w_prod;
    logic [IDX_W:0]        w_n;
    logic                  w_test_ok, w_last, w_t_better;
    logic [c_SQ_W+1:0]     w_rem_sh, w_trial;

    assign w_n = (num_spheres > (IDX_W+1)'(N_SPHERES)) ? (IDX_W+1)'(N_SPHERES) : num_spheres;

    // Operand order fixes the accumulation schedule used in S_MAC.
    always_comb begin
        w_ma = r_r;
        w_mb = r_r;
        case (r_cnt[2:0])
            3'd0:    begin w_ma = r_dx; w_mb = r_cx;  end
            3'd1:    begin w_ma = r_dy; w_mb = r_cy;  end
            3'd2:    begin w_ma = r_dz; w_mb = r_cz;  end
            3'd3:    begin w_ma = r_cx; w_mb = r_cx;  end
            3'd4:    begin w_ma = r_cy; w_mb = r_cy;  end
            3'd5:    begin w_ma = r_cz; w_mb = r_cz;  end
            3'd6:    begin w_ma = r_v;  w_mb = r_v;   end
            default: begin w_ma = r_r;  w_mb = r_r;   end
        endcase
    end

    assign w_prod     = w_ma * w_mb;
    assign w_mp       = W'(w_prod >>> FRAC);
    assign w_vmr      = r_v - r_r;
    assign w_ccmv     = r_cc - r_vsq;
    assign w_disc     = r_rsq - w_ccmv;
    assign w_test_ok  = (r_tbest > w_vmr) && (r_rsq > w_ccmv);
    assign w_rem_sh   = {r_rem, r_rad[2*c_SQ_W-1 -: 2]};
    assign w_trial    = {r_root, 2'b01};
    assign w_s        = {{(W-c_SQ_W){1'b0}}, r_root};
    assign w_t        = r_v - w_s;
    assign w_t_better = !w_t[W-1] && (w_t != '0) && (w_t < r_tbest);
    assign w_last     = ({1'b0, r_idx} == (r_n - (IDX_W+1)'(1)));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nx = (w_n == '0) ? S_DONE : S_FETCH;
            S_FETCH:  w_state_nx = S_LOAD;
            S_LOAD:   w_state_nx = S_MAC;
            S_MAC:    if (r_cnt == c_CNT_W'(7)) w_state_nx = S_TEST;
            S_TEST:   w_state_nx = w_test_ok ? S_SQRT : S_NEXT;
            S_SQRT:   if (r_cnt == c_CNT_W'(c_SQRT_CYC - 1)) w_state_nx = S_UPDATE;
            S_UPDATE: w_state_nx = S_NEXT;
            S_NEXT:   w_state_nx = w_last ? S_DONE : S_FETCH;
            S_DONE:   if (result_ready) w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dx <= '0; r_dy <= '0; r_dz <= '0;
            r_cx <= '0; r_cy <= '0; r_cz <= '0; r_r <= '0;
            r_v <= '0; r_cc <= '0; r_vsq <= '0; r_rsq <= '0; r_tbest <= '0;
            r_n <= '0; r_idx <= '0; r_best_idx <= '0; r_hit <= 1'b0;
            r_hit_o <= 1'b0; r_hidx_o <= '0; r_t_o <= '0;
            r_cnt <= '0; r_rad <= '0; r_rem <= '0; r_root <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_dx       <= ray_dir[3*W-1:2*W];
                    r_dy       <= ray_dir[2*W-1:W];
                    r_dz       <= ray_dir[W-1:0];
                    r_tbest    <= tmax;
                    r_n        <= w_n;
                    r_idx      <= '0;
                    r_best_idx <= '0;
                    r_hit      <= 1'b0;
                    // An empty scan goes straight to DONE, so publish its result now.
                    if (w_n == '0) begin
                        r_hit_o  <= 1'b0;
                        r_hidx_o <= '0;
                        r_t_o    <= tmax;
                    end
                end
                S_LOAD: begin
                    r_cx  <= sphere_center[3*W-1:2*W];
                    r_cy  <= sphere_center[2*W-1:W];
                    r_cz  <= sphere_center[W-1:0];
                    r_r   <= sphere_radius;
                    r_cnt <= '0;
                end
                S_MAC: begin
                    case (r_cnt[2:0])
                        3'd0:      r_v   <= w_mp;
                        3'd1,3'd2: r_v   <= r_v + w_mp;
                        3'd3:      r_cc  <= w_mp;
                        3'd4,3'd5: r_cc  <= r_cc + w_mp;
                        3'd6:      r_vsq <= w_mp;
                        default:   r_rsq <= w_mp;
                    endcase
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                S_TEST: begin
                    r_rad  <= {w_disc, {FRAC{1'b0}}};
                    r_rem  <= '0;
                    r_root <= '0;
                    r_cnt  <= '0;
                end
                S_SQRT: begin
                    r_rad <= {r_rad[2*c_SQ_W-3:0], 2'b00};
                    if (w_rem_sh >= w_trial) begin
                        r_rem  <= c_SQ_W'(w_rem_sh - w_trial);
                        r_root <= {r_root[c_SQ_W-2:0], 1'b1};
                    end else begin
                        r_rem  <= w_rem_sh[c_SQ_W-1:0];
                        r_root <= {r_root[c_SQ_W-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                S_UPDATE: if (w_t_better) begin
                    r_tbest    <= w_t;
                    r_hit      <= 1'b1;
                    r_best_idx <= r_idx;
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_hit_o  <= r_hit;
                        r_hidx_o <= r_best_idx;
                        r_t_o    <= r_tbest;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready  = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign result_valid = (r_state == S_DONE);
    assign sphere_addr  = r_idx;
    assign hit          = r_hit_o;
    assign hit_index    = r_hidx_o;
    assign t_hit        = r_t_o;

endmodule
`default_nettype wire

// File: tb/tb_nearest_sphere_hit.sv
`default_nettype none
// tb_nearest_sphere_hit -- directed ray scans checked against a plain-arithmetic
// reference model of the nearest-hit search.
module tb_nearest_sphere_hit;
    localparam int W = 32, FRAC = 16, NS = 16, IW = 4;
    localparam int ONE = 65536;

    logic Clk = 1'b0, Reset_n = 1'b0, start = 1'b0, result_ready = 1'b0;
    logic [3*W-1:0] ray_dir = '0;
    logic [W-1:0]   tmax = '0;
    logic [IW:0]    num_spheres = '0;
    logic [IW-1:0]  sphere_addr, hit_index;
    logic [3*W-1:0] sphere_center = '0;
    logic [W-1:0]   sphere_radius = '0, t_hit;
    logic           start_ready, result_valid, hit, busy;

    int mem_x[NS], mem_y[NS], mem_z[NS], mem_r[NS];
    int n_pass = 0, n_total = 0;
    bit armed = 1'b0, logging = 1'b0;
    bit exp_hit;
    int exp_idx;
    logic [31:0] exp_t;
    int addr_log[$];

    nearest_sphere_hit #(.W(W), .FRAC(FRAC), .N_SPHERES(NS), .IDX_W(IW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .start_ready(start_ready),
        .ray_dir(ray_dir), .tmax(tmax), .num_spheres(num_spheres),
        .sphere_addr(sphere_addr), .sphere_center(sphere_center),
        .sphere_radius(sphere_radius), .result_valid(result_valid),
        .result_ready(result_ready), .hit(hit), .hit_index(hit_index),
        .t_hit(t_hit), .busy(busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        sphere_center <= {mem_x[sphere_addr], mem_y[sphere_addr], mem_z[sphere_addr]};
        sphere_radius <= mem_r[sphere_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    function automatic int fx(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> FRAC);
    endfunction

    function automatic longint isqrt(input longint x);
        longint s, c;
        s = 0;
        for (int b = 24; b >= 0; b--) begin
            c = s | (longint'(1) << b);
            if (c * c <= x) s = c;
        end
        return s;
    endfunction

    // Latency = clock edges from the accept edge up to and including the first
    // edge that samples result_valid high.
    task automatic model(input int n_req, output bit h, output int idx,
                         output logic [31:0] t, output int lat, output int nn);
        int dx, dy, dz, tb, v, cc, vsq, rsq, disc, tt;
        longint s;
        dx = ray_dir[95:64]; dy = ray_dir[63:32]; dz = ray_dir[31:0];
        nn = (n_req > NS) ? NS : n_req;
        tb = tmax; h = 1'b0; idx = 0; lat = 2;
        for (int i = 0; i < nn; i++) begin
            v   = fx(dx, mem_x[i]) + fx(dy, mem_y[i]) + fx(dz, mem_z[i]);
            cc  = fx(mem_x[i], mem_x[i]) + fx(mem_y[i], mem_y[i]) + fx(mem_z[i], mem_z[i]);
            vsq = fx(v, v);
            rsq = fx(mem_r[i], mem_r[i]);
            if (tb > v - mem_r[i] && rsq > cc - vsq) begin
                disc = rsq - (cc - vsq);
                s = isqrt(longint'(unsigned'(disc)) << FRAC);
                tt = v - int'(s);
                if (tt > 0 && tt < tb) begin tb = tt; h = 1'b1; idx = i; end
                lat += 13 + (W + FRAC) / 2;
            end else begin
                lat += 12;
            end
        end
        t = tb;
    endtask

    task automatic set_sph(input int i, input int x, input int y, input int z, input int r);
        mem_x[i] = x; mem_y[i] = y; mem_z[i] = z; mem_r[i] = r;
    endtask

    // Stable, correct result on every cycle it is presented.
    always @(negedge Clk) begin
        if (Reset_n && result_valid) begin
            chk("valid only when expected", armed, 1);
            chk("hit", hit, exp_hit);
            chk("hit_index", hit_index, exp_idx);
            chk("t_hit", t_hit, exp_t);
            chk("start_ready in DONE", start_ready, 0);
        end
    end

    always @(negedge Clk) begin
        if (logging && busy && (addr_log.size() == 0 || addr_log[$] != int'(sphere_addr)))
            addr_log.push_back(int'(sphere_addr));
    end

    task automatic scan(input string tag, input int nreq, input int hold,
                        output bit h, output int idx, output logic [31:0] t, output int lat);
        int nn, got;
        model(nreq, h, idx, t, lat, nn);
        exp_hit = h; exp_idx = idx; exp_t = t; armed = 1'b1;
        @(negedge Clk);
        num_spheres = nreq[IW:0];
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        addr_log.delete();
        logging = 1'b1;
        got = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge Clk);
            if (result_valid) begin got = k + 1; break; end
        end
        logging = 1'b0;
        chk({tag, " latency"}, got, lat);
        if (hold > 0) begin
            start = 1'b1;
            repeat (hold) @(negedge Clk);
            start = 1'b0;
            chk({tag, " valid held"}, result_valid, 1);
        end
        result_ready = 1'b1;
        @(posedge Clk);
        #1 result_ready = 1'b0;
        armed = 1'b0;
        @(negedge Clk);
        chk({tag, " valid drops"}, result_valid, 0);
        chk({tag, " start_ready back"}, start_ready, 1);
        chk({tag, " t_hit kept"}, t_hit, t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit h;
        int idx, lat;
        logic [31:0] t;
        bit seq_ok;

        for (int i = 0; i < NS; i++) set_sph(i, 0, 0, 0, 0);
        #12;
        chk("reset result_valid", result_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset t_hit", t_hit, 0);
        chk("reset sphere_addr", sphere_addr, 0);
        @(negedge Clk) Reset_n = 1'b1;
        @(negedge Clk);
        chk("reset start_ready", start_ready, 1);

        ray_dir = {32'd0, 32'd0, 32'h0001_0000};
        tmax    = 32'h7FFF_FFFF;

        set_sph(0, 0, 0, 100*ONE, 32*ONE);
        scan("single", 1, 10, h, idx, t, lat);
        chk("model single t", t, 32'h0044_0000);
        chk("model single lat", lat, 39);
        chk("model single hit", h, 1);

        set_sph(0, 100*ONE, 0, 100*ONE, 32*ONE);
        scan("miss", 1, 0, h, idx, t, lat);
        chk("model miss hit", h, 0);
        chk("model miss lat", lat, 14);

        set_sph(0, 0, 0, 200*ONE, 32*ONE);
        set_sph(1, 0, 0, 100*ONE, 32*ONE);
        scan("nearest", 2, 0, h, idx, t, lat);
        chk("model nearest idx", idx, 1);
        chk("model nearest t", t, 32'h0044_0000);

        set_sph(0, 0, 0, 100*ONE, 32*ONE);
        scan("tie", 2, 0, h, idx, t, lat);
        chk("model tie idx", idx, 0);

        set_sph(0, 0, 0, -100*ONE, 32*ONE);
        scan("behind", 1, 0, h, idx, t, lat);
        chk("model behind hit", h, 0);

        tmax = 32'h0012_3456;
        scan("empty", 0, 0, h, idx, t, lat);
        chk("model empty t", t, 32'h0012_3456);
        chk("model empty lat", lat, 2);

        tmax = 32'h7FFF_FFFF;
        for (int i = 0; i < NS; i++)
            set_sph(i, (i % 3 == 0) ? 60*ONE : 0, 0, (170 - 5*i)*ONE, 32*ONE);
        scan("clip", NS + 3, 0, h, idx, t, lat);
        chk("model clip idx", idx, 14);
        seq_ok = (addr_log.size() == NS);
        for (int i = 0; i < addr_log.size(); i++)
            if (addr_log[i] != i) seq_ok = 1'b0;
        chk("clip address sequence 0..N-1", seq_ok, 1);

        set_sph(0, 0, 0, 100*ONE, 32*ONE);
        @(negedge Clk);
        num_spheres = 5'd1;
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (20) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("midreset result_valid", result_valid, 0);
        chk("midreset busy", busy, 0);
        chk("midreset start_ready", start_ready, 1);
        chk("midreset hit", hit, 0);
        chk("midreset hit_index", hit_index, 0);
        chk("midreset t_hit", t_hit, 0);
        chk("midreset sphere_addr", sphere_addr, 0);
        @(negedge Clk) Reset_n = 1'b1;
        repeat (60) @(negedge Clk);

        scan("after reset", 1, 0, h, idx, t, lat);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
